riscv_dmem_dp_bram: RTL and testbench

True dual-port synchronous block RAM serving as the RISC-V kernel's data memory. Port A carries scalar 32-bit accesses. Port B carries the upper word of 64-bit vector accesses; the integration layer drives addr_b = addr_a + 1. Both ports share one clock. The array powers up holding the kernel's test data set.

---
 rtl/riscv_dmem_dp_bram.sv | 112 +++++++++++
 tb/tb_riscv_dmem_dp_bram.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_dp_bram.sv
`default_nettype none
// ============================================================================
// Module  : riscv_dmem_dp_bram
// Brief   : True dual-port synchronous data RAM. Port A serves scalar words,
//           port B the upper word of 64-bit vector accesses.
// Revision: 1.0 - initial release
// ============================================================================
module riscv_dmem_dp_bram #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 6,
    parameter int DEPTH   = 64,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] din_a,
    output logic [DWIDTH-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0] din_b,
    output logic [DWIDTH-1:0] dout_b
);

    typedef logic [DWIDTH-1:0] mem_t [DEPTH];

    localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH+1)'(DEPTH);

    function automatic logic [DWIDTH-1:0] init_word(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h08;
            1:       w = 32'h07;
            2:       w = 32'h03;
            3:       w = 32'h2C;
            4:       w = 32'h01;
            5:       w = 32'h05;
            6:       w = 32'h18;
            7:       w = 32'h06;
            8:       w = 32'h02;
            9:       w = 32'h0D;
            default: w = 32'h0;
        endcase
        return DWIDTH'(w);
    endfunction

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = (INIT_EN != 0) ? init_word(i) : '0;
        end
        return img;
    endfunction

    // Power-up image is carried by the declaration so the array maps onto BRAM init.
    logic [DWIDTH-1:0] mem [DEPTH] = init_image();

    logic in_range_a;
    logic in_range_b;
    logic wr_a;
    logic wr_b;

    assign in_range_a = ({1'b0, addr_a} < DEPTH_LIM);
    assign in_range_b = ({1'b0, addr_b} < DEPTH_LIM);

    // Reset is used as a write qualifier so the array itself never sees a reset.
    assign wr_a = rst_n & en_a & we_a & in_range_a;
    assign wr_b = rst_n & en_b & we_b & in_range_b & ~(wr_a & (addr_a == addr_b));

    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem[addr_a] <= din_a;
        end
        if (wr_b) begin
            mem[addr_b] <= din_b;
        end
    end

    // Same-port write-first; the other port reads the pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a <= '0;
        end else if (en_a) begin
            if (!in_range_a) begin
                dout_a <= '0;
            end else if (we_a) begin
                dout_a <= din_a;
            end else begin
                dout_a <= mem[addr_a];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_b <= '0;
        end else if (en_b) begin
            if (!in_range_b) begin
                dout_b <= '0;
            end else if (we_b) begin
                dout_b <= din_b;
            end else begin
                dout_b <= mem[addr_b];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_dp_bram.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_dmem_dp_bram
// Brief   : Self-checking bench: directed vector table, reset sequences and
//           randomized traffic against a word-array reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_dp_bram;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en_a = 1'b0;
    logic          we_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] din_a = '0;
    logic [DW-1:0] dout_a;
    logic          en_b = 1'b0;
    logic          we_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] din_b = '0;
    logic [DW-1:0] dout_b;

    always #5 clk = ~clk;

    riscv_dmem_dp_bram #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .DEPTH  (DEPTH),
        .INIT_EN(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_a  (en_a),
        .we_a  (we_a),
        .addr_a(addr_a),
        .din_a (din_a),
        .dout_a(dout_a),
        .en_b  (en_b),
        .we_b  (we_b),
        .addr_b(addr_b),
        .din_b (din_b),
        .dout_b(dout_b)
    );

    typedef struct {
        logic          en_a;
        logic          we_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] din_a;
        logic          en_b;
        logic          we_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] din_b;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: reads see pre-edge contents, own-port write is echoed, A wins a collision.
    task automatic model_step();
        logic a_writes;
        a_writes = en_a && we_a;
        if (en_a) exp_a = we_a ? din_a : model[addr_a];
        if (en_b) exp_b = we_b ? din_b : model[addr_b];
        if (en_b && we_b && !(a_writes && addr_a == addr_b)) model[addr_b] = din_b;
        if (a_writes) model[addr_a] = din_a;
    endtask

    task automatic drive(input vec_t v);
        en_a = v.en_a; we_a = v.we_a; addr_a = v.addr_a; din_a = v.din_a;
        en_b = v.en_b; we_b = v.we_b; addr_b = v.addr_b; din_b = v.din_b;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [11];

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model[0] = 32'h08; model[1] = 32'h07; model[2] = 32'h03; model[3] = 32'h2C;
        model[4] = 32'h01; model[5] = 32'h05; model[6] = 32'h18; model[7] = 32'h06;
        model[8] = 32'h02; model[9] = 32'h0D;

        //              en_a  we_a  addr_a din_a          en_b  we_b  addr_b din_b          exp_a          exp_b
        vecs[0]  = '{1'b1, 1'b0, 6'd0, 32'h0,         1'b1, 1'b0, 6'd1, 32'h0,         32'h08,        32'h07};
        vecs[1]  = '{1'b1, 1'b0, 6'd8, 32'h0,         1'b1, 1'b0, 6'd9, 32'h0,         32'h02,        32'h0D};
        vecs[2]  = '{1'b1, 1'b1, 6'd0, 32'h01,        1'b1, 1'b1, 6'd1, 32'h05,        32'h01,        32'h05};
        vecs[3]  = '{1'b1, 1'b0, 6'd0, 32'h0,         1'b1, 1'b0, 6'd1, 32'h0,         32'h01,        32'h05};
        vecs[4]  = '{1'b1, 1'b1, 6'd4, 32'hAAAA0000,  1'b1, 1'b1, 6'd4, 32'hBBBB0000,  32'hAAAA0000,  32'hBBBB0000};
        vecs[5]  = '{1'b1, 1'b0, 6'd4, 32'h0,         1'b1, 1'b0, 6'd4, 32'h0,         32'hAAAA0000,  32'hAAAA0000};
        vecs[6]  = '{1'b1, 1'b1, 6'd2, 32'h1234,      1'b1, 1'b0, 6'd2, 32'h0,         32'h1234,      32'h03};
        vecs[7]  = '{1'b1, 1'b0, 6'd3, 32'h0,         1'b1, 1'b0, 6'd2, 32'h0,         32'h2C,        32'h1234};
        vecs[8]  = '{1'b0, 1'b0, 6'd9, 32'h0,         1'b1, 1'b0, 6'd5, 32'h0,         32'h2C,        32'h05};
        vecs[9]  = '{1'b0, 1'b1, 6'd7, 32'hDEADBEEF,  1'b1, 1'b0, 6'd7, 32'h0,         32'h2C,        32'h06};
        vecs[10] = '{1'b1, 1'b0, 6'd7, 32'h0,         1'b1, 1'b0, 6'd6, 32'h0,         32'h06,        32'h18};

        // Power-up reset
        #1 rst_n = 1'b0;
        #1;
        check("reset_a", dout_a, 32'h0);
        check("reset_b", dout_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = '0;
        exp_b = '0;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i]);
            cycle();
            check($sformatf("vec%0d_a", i), dout_a, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), dout_b, vecs[i].exp_b);
        end

        // Asynchronous reset mid-operation, with writes attempted while held
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_a", dout_a, 32'h0);
        check("async_rst_b", dout_b, 32'h0);
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd0; din_a = 32'hFFFFFFFF;
        en_b = 1'b1; we_b = 1'b1; addr_b = 6'd1; din_b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        check("rst_hold_a", dout_a, 32'h0);
        check("rst_hold_b", dout_b, 32'h0);
        #2 rst_n = 1'b1;
        exp_a = '0;
        exp_b = '0;
        we_a = 1'b0; we_b = 1'b0;
        cycle();
        check("retain_a", dout_a, 32'h01);
        check("retain_b", dout_b, 32'h05);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [1:0] mode;
            en_a   = ($urandom_range(0, 3) != 0);
            we_a   = ($urandom_range(0, 2) == 0);
            en_b   = ($urandom_range(0, 3) != 0);
            we_b   = ($urandom_range(0, 2) == 0);
            addr_a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            mode   = 2'($urandom_range(0, 3));
            case (mode)
                2'd0:    addr_b = addr_a;
                2'd3:    addr_b = AW'($urandom);
                default: addr_b = addr_a + 6'd1;
            endcase
            din_a  = $urandom;
            din_b  = $urandom;
            cycle();
            check($sformatf("rnd%0d_a", n), dout_a, exp_a);
            check($sformatf("rnd%0d_b", n), dout_b, exp_b);
        end

        // Final sweep of the whole array through both ports
        en_a = 1'b1; we_a = 1'b0; en_b = 1'b1; we_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            addr_a = AW'(k);
            addr_b = AW'(k) + 6'd1;
            cycle();
            check($sformatf("sweep%0d_a", k), dout_a, exp_a);
            check($sformatf("sweep%0d_b", k), dout_b, exp_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
